// File: rtl/icache_refill_ctrl_if.sv
// Word-wide instruction memory read port (req/ack handshake) used by the I-cache refill sequencer.
interface icache_refill_ctrl_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss sequencer: fetches a 4-word line over mem req/ack and emits a one-cycle fill.
// Define REFILL_CWF_EN for critical-word-first beat order with crit_valid/crit_word.
module icache_refill_ctrl #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     miss_valid,
    input  logic [31:0]              miss_addr,
    input  logic                     flush,
    output logic                     stall,
    output logic                     fill_valid,
    output logic [31:0]              fill_addr,
    output logic [LINE_WORDS*32-1:0] fill_line,
    output logic                     crit_valid,
    output logic [31:0]              crit_word,
    icache_refill_ctrl_if.master     mem,
    output logic [CNT_W-1:0]         miss_count
);

    localparam int unsigned BEAT_W  = $clog2(LINE_WORDS);
    localparam int unsigned LADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t                      state;
    logic [LADDR_W-1:0]          line_addr;
    logic [BEAT_W-1:0]           beat;
    logic [BEAT_W-1:0]           ack_cnt;
    logic [BEAT_W-1:0]           start_beat;
    logic [BEAT_W-1:0]           beat_inc;
    logic [LINE_WORDS-1:0][31:0] line_buf;
    logic [LINE_WORDS-1:0][31:0] buf_nxt;
    logic                        miss_take;
    logic                        last_ack;
    logic                        unused_addr;

    assign miss_take   = miss_valid & ~flush;
    // Fetch must freeze in the miss cycle itself, before the FSM has moved.
    assign stall       = (state != IDLE) | miss_take;
    assign beat_inc    = beat + BEAT_W'(1);
    assign last_ack    = (ack_cnt == BEAT_W'(LINE_WORDS - 1));
    assign unused_addr = ^miss_addr[3:0];

`ifdef REFILL_CWF_EN
    assign start_beat = BEAT_W'(miss_addr[3:2]);
`else
    assign start_beat = '0;
`endif

    // Line buffer with the current beat's data merged in, so the last word lands in the fill directly.
    always_comb begin
        buf_nxt       = line_buf;
        buf_nxt[beat] = mem.mem_rdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            line_addr    <= '0;
            beat         <= '0;
            ack_cnt      <= '0;
            line_buf     <= '0;
            fill_valid   <= 1'b0;
            fill_addr    <= '0;
            fill_line    <= '0;
            crit_valid   <= 1'b0;
            crit_word    <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            miss_count   <= '0;
        end else begin
            fill_valid <= 1'b0;
            crit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_take) begin
                        state        <= REQ;
                        line_addr    <= miss_addr[31:4];
                        beat         <= start_beat;
                        ack_cnt      <= '0;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= {miss_addr[31:4], start_beat, 2'b00};
                        if (miss_count != '1) begin
                            miss_count <= miss_count + CNT_W'(1);
                        end
                    end
                end
                REQ: begin
                    // Flush wins over a same-cycle ack: the beat is consumed but never exposed.
                    if (flush) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                    end else if (mem.mem_ack) begin
                        line_buf     <= buf_nxt;
                        beat         <= beat_inc;
                        ack_cnt      <= ack_cnt + BEAT_W'(1);
                        mem.mem_addr <= {line_addr, beat_inc, 2'b00};
`ifdef REFILL_CWF_EN
                        if (ack_cnt == '0) begin
                            crit_valid <= 1'b1;
                            crit_word  <= mem.mem_rdata;
                        end
`endif
                        if (last_ack) begin
                            state       <= FILL;
                            mem.mem_req <= 1'b0;
                            fill_valid  <= 1'b1;
                            fill_line   <= buf_nxt;
                            fill_addr   <= {line_addr, 4'b0000};
                        end
                    end
                end
                FILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
